cpu_bus_arbiter: RTL and testbench

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Two-port (instruction A / data B) arbiter onto a single request/ready CPU bus.
// Fair tie-break on simultaneous requests, optional bus-wait timeout, and a release cycle per transfer.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        i_clock,
  input  logic        i_reset,

  input  logic        i_a_request,
  input  logic        i_a_rw,
  input  logic [31:0] i_a_address,
  input  logic [31:0] i_a_wdata,
  output logic        o_a_ready,
  output logic        o_a_error,
  output logic [31:0] o_a_rdata,

  input  logic        i_b_request,
  input  logic        i_b_rw,
  input  logic [31:0] i_b_address,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_ready,
  output logic        o_b_error,
  output logic [31:0] o_b_rdata,

  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUS     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Last counter value before the forced error completion; unused when TIMEOUT is 0.
  localparam int unsigned TIMEOUT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [1:0]  r_state;
  logic        r_grant_b;
  logic        r_last_grant_b;
  logic [15:0] r_wait_cnt;

  logic        r_bus_request;
  logic        r_bus_rw;
  logic [31:0] r_bus_address;
  logic [31:0] r_bus_wdata;

  logic        r_a_ready;
  logic        r_a_error;
  logic [31:0] r_a_rdata;
  logic        r_b_ready;
  logic        r_b_error;
  logic [31:0] r_b_rdata;

  logic        w_any_request;
  logic        w_pick_b;
  logic        w_timeout_hit;
  logic        w_win_rw;
  logic [31:0] w_win_address;
  logic [31:0] w_win_wdata;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    w_any_request = i_a_request | i_b_request;
    w_pick_b      = i_b_request & (~i_a_request | ~r_last_grant_b);
    w_win_rw      = w_pick_b ? i_b_rw      : i_a_rw;
    w_win_address = w_pick_b ? i_b_address : i_a_address;
    w_win_wdata   = w_pick_b ? i_b_wdata   : i_a_wdata;
    w_timeout_hit = (TIMEOUT != 0) && ({16'd0, r_wait_cnt} == TIMEOUT_LAST);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_grant_b      <= 1'b0;
      r_last_grant_b <= 1'b1;
      r_wait_cnt     <= 16'd0;
      r_bus_request  <= 1'b0;
      r_bus_rw       <= 1'b0;
      r_bus_address  <= 32'd0;
      r_bus_wdata    <= 32'd0;
      r_a_ready      <= 1'b0;
      r_a_error      <= 1'b0;
      r_a_rdata      <= 32'd0;
      r_b_ready      <= 1'b0;
      r_b_error      <= 1'b0;
      r_b_rdata      <= 32'd0;
    end else begin
      r_a_ready <= 1'b0;
      r_a_error <= 1'b0;
      r_b_ready <= 1'b0;
      r_b_error <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any_request) begin
            r_grant_b      <= w_pick_b;
            r_last_grant_b <= w_pick_b;
            r_bus_request  <= 1'b1;
            r_bus_rw       <= w_win_rw;
            r_bus_address  <= w_win_address;
            r_bus_wdata    <= w_win_wdata;
            r_wait_cnt     <= 16'd0;
            r_state        <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (i_bus_ready) begin
            r_bus_request <= 1'b0;
            if (r_grant_b) begin
              r_b_ready <= 1'b1;
              r_b_rdata <= i_bus_rdata;
            end else begin
              r_a_ready <= 1'b1;
              r_a_rdata <= i_bus_rdata;
            end
            r_state <= ST_RELEASE;
          end else if (w_timeout_hit) begin
            r_bus_request <= 1'b0;
            if (r_grant_b) begin
              r_b_ready <= 1'b1;
              r_b_error <= 1'b1;
              r_b_rdata <= 32'd0;
            end else begin
              r_a_ready <= 1'b1;
              r_a_error <= 1'b1;
              r_a_rdata <= 32'd0;
            end
            r_state <= ST_RELEASE;
          end else if (r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end

        // Winner still holds its request this cycle; skip sampling so it is not re-granted.
        ST_RELEASE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_bus_request = r_bus_request;
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_a_ready     = r_a_ready;
  assign o_a_error     = r_a_error;
  assign o_a_rdata     = r_a_rdata;
  assign o_b_ready     = r_b_ready;
  assign o_b_error     = r_b_error;
  assign o_b_rdata     = r_b_rdata;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed self-checking bench for cpu_bus_arbiter with TIMEOUT = 8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_rw = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_error;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0, b_rw = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_error;
  logic [31:0] b_rdata;
  logic        bus_req, bus_rw;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_bus_arbiter #(.TIMEOUT(8)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_a_request   (a_req),
    .i_a_rw        (a_rw),
    .i_a_address   (a_addr),
    .i_a_wdata     (a_wdata),
    .o_a_ready     (a_ready),
    .o_a_error     (a_error),
    .o_a_rdata     (a_rdata),
    .i_b_request   (b_req),
    .i_b_rw        (b_rw),
    .i_b_address   (b_addr),
    .i_b_wdata     (b_wdata),
    .o_b_ready     (b_ready),
    .o_b_error     (b_error),
    .o_b_rdata     (b_rdata),
    .o_bus_request (bus_req),
    .o_bus_rw      (bus_rw),
    .o_bus_address (bus_addr),
    .o_bus_wdata   (bus_wdata),
    .i_bus_ready   (bus_ready),
    .i_bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset applied between edges must clear outputs without a clock.
    #1 rst = 1'b1;
    #1;
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    check_eq("rst_bus_rw", bus_rw, 0);
    check_eq("rst_ready", {a_ready, a_error, b_ready, b_error}, 0);
    check_eq("rst_rdata", a_rdata | b_rdata, 0);
    tick();
    tick();
    rst = 1'b0;

    // V-2: tie after reset -> A, then B, then A on the next tie.
    a_req = 1; a_addr = 32'h100; b_req = 1; b_addr = 32'h200;
    tick();
    check_eq("tie1_bus_req", bus_req, 1);
    check_eq("tie1_addr_a", bus_addr, 32'h100);
    bus_ready = 1; bus_rdata = 32'h11;
    tick();
    check_eq("tie1_a_ready", a_ready, 1);
    check_eq("tie1_b_ready", b_ready, 0);
    check_eq("tie1_a_rdata", a_rdata, 32'h11);
    bus_ready = 0;
    tick();
    check_eq("tie1_release_idle", bus_req, 0);
    a_req = 0;
    tick();
    check_eq("tie1_b_granted", bus_req, 1);
    check_eq("tie1_addr_b", bus_addr, 32'h200);
    bus_ready = 1; bus_rdata = 32'h22;
    tick();
    check_eq("tie1_b_ready", b_ready, 1);
    check_eq("tie1_a_not_ready", a_ready, 0);
    check_eq("tie1_b_rdata", b_rdata, 32'h22);
    check_eq("tie1_a_rdata_hold", a_rdata, 32'h11);
    bus_ready = 0;
    tick();
    a_req = 1;
    tick();
    check_eq("tie2_addr_a", bus_addr, 32'h100);
    bus_ready = 1; bus_rdata = 32'h33;
    tick();
    check_eq("tie2_a_ready", a_ready, 1);
    bus_ready = 0;
    tick();
    a_req = 0;
    tick();
    check_eq("tie2_then_b", bus_addr, 32'h200);
    bus_ready = 1; bus_rdata = 32'h44;
    tick();
    check_eq("tie2_b_ready", b_ready, 1);
    bus_ready = 0;
    tick();
    b_req = 0;
    tick();
    check_eq("tie2_idle", bus_req, 0);

    // V-1: A read, bus ready after 3 cycles; stale A request held over release.
    a_req = 1; a_rw = 0; a_addr = 32'h0000_1000;
    tick();
    check_eq("v1_bus_req", bus_req, 1);
    check_eq("v1_addr", bus_addr, 32'h0000_1000);
    check_eq("v1_rw", bus_rw, 0);
    tick();
    tick();
    check_eq("v1_wait_no_ready", a_ready, 0);
    bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    check_eq("v1_a_ready", a_ready, 1);
    check_eq("v1_a_error", a_error, 0);
    check_eq("v1_b_ready", b_ready, 0);
    check_eq("v1_a_rdata", a_rdata, 32'hDEAD_BEEF);
    check_eq("v1_bus_req_drop", bus_req, 0);
    bus_ready = 0;
    tick();
    check_eq("v1_ready_one_cycle", a_ready, 0);
    check_eq("v1_no_regrant", bus_req, 0);
    a_req = 0;
    tick();
    check_eq("v1_idle", bus_req, 0);

    // V-3: B write; A requests during B's transfer and waits for release.
    b_req = 1; b_rw = 1; b_addr = 32'h8000_0010; b_wdata = 32'h1234_5678;
    tick();
    check_eq("v3_bus_rw", bus_rw, 1);
    check_eq("v3_addr", bus_addr, 32'h8000_0010);
    check_eq("v3_wdata", bus_wdata, 32'h1234_5678);
    a_req = 1; a_rw = 0; a_addr = 32'h3000;
    tick();
    tick();
    check_eq("v3_wdata_stable", bus_wdata, 32'h1234_5678);
    check_eq("v3_addr_stable", bus_addr, 32'h8000_0010);
    check_eq("v3_a_ignored", a_ready, 0);
    bus_ready = 1; bus_rdata = 32'hCAFE_0000;
    tick();
    check_eq("v3_b_ready", b_ready, 1);
    check_eq("v3_a_ready", a_ready, 0);
    check_eq("v3_b_rdata", b_rdata, 32'hCAFE_0000);
    bus_ready = 0;
    tick();
    check_eq("v3_release", bus_req, 0);
    b_req = 0; b_rw = 0;
    tick();
    check_eq("v3_a_granted", bus_req, 1);
    check_eq("v3_a_addr", bus_addr, 32'h3000);
    check_eq("v3_a_rw", bus_rw, 0);
    bus_ready = 1; bus_rdata = 32'h33;
    tick();
    check_eq("v3_a_done", a_ready, 1);
    bus_ready = 0;
    tick();
    a_req = 0;
    tick();

    // V-4: B read with a bus that never answers; TIMEOUT = 8.
    b_req = 1; b_addr = 32'h4000;
    tick();
    check_eq("v4_bus_req", bus_req, 1);
    for (int i = 1; i <= 7; i++) tick();
    check_eq("v4_still_waiting", bus_req, 1);
    check_eq("v4_no_early_ready", b_ready, 0);
    tick();
    check_eq("v4_bus_req_drop", bus_req, 0);
    check_eq("v4_b_ready", b_ready, 1);
    check_eq("v4_b_error", b_error, 1);
    check_eq("v4_b_rdata", b_rdata, 0);
    check_eq("v4_a_quiet", {a_ready, a_error}, 0);
    tick();
    check_eq("v4_pulse_end", {b_ready, b_error}, 0);
    b_req = 0;
    tick();

    // V-5: reset two cycles into BUS abandons the transfer.
    a_req = 1; a_addr = 32'h5000;
    tick();
    check_eq("v5_bus_req", bus_req, 1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("v5_async_bus_req", bus_req, 0);
    check_eq("v5_async_addr", bus_addr, 0);
    check_eq("v5_async_flags", {a_ready, a_error, b_ready, b_error}, 0);
    check_eq("v5_async_a_rdata", a_rdata, 0);
    bus_ready = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 0; bus_ready = 0; a_req = 0;
    tick();
    check_eq("v5_no_ready", a_ready | b_ready, 0);
    a_req = 1; a_addr = 32'h5000;
    tick();
    check_eq("v5_post_addr", bus_addr, 32'h5000);
    bus_ready = 1; bus_rdata = 32'h55;
    tick();
    check_eq("v5_post_ready", a_ready, 1);
    check_eq("v5_post_rdata", a_rdata, 32'h55);
    bus_ready = 0;
    tick();
    a_req = 0;
    tick();

    // V-6: bus ready in IDLE and in RELEASE must be ignored.
    bus_ready = 1; bus_rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    check_eq("v6_idle_ready", {a_ready, b_ready}, 0);
    check_eq("v6_idle_a_rdata", a_rdata, 32'h55);
    check_eq("v6_idle_b_rdata", b_rdata, 0);
    bus_ready = 0;
    b_req = 1; b_addr = 32'h6000;
    tick();
    bus_ready = 1; bus_rdata = 32'h66;
    tick();
    check_eq("v6_b_ready", b_ready, 1);
    bus_rdata = 32'hBAD1_BAD1;
    tick();
    check_eq("v6_release_ready", {a_ready, b_ready}, 0);
    check_eq("v6_release_b_rdata", b_rdata, 32'h66);
    check_eq("v6_release_a_rdata", a_rdata, 32'h55);
    b_req = 0; bus_ready = 0;
    tick();
    check_eq("v6_end_idle", bus_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
